disp_scan_hex: RTL

Parametrised, time-multiplexed hexadecimal seven-segment display driver. It latches a packed word of DIGITS hex nibbles with per-digit decimal-point and blank flags, then scans the digits one at a time onto a shared active-low segment bus. Scanning includes a dead-time gap between digits and optional leading-zero suppression. It replaces switch-driven, single-digit anode selection at the board top level and drives SEGMENT/AN directly.

---
 rtl/disp_scan_hex.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/disp_scan_hex.sv
// Time-multiplexed hex seven-segment driver: latches DIGITS nibbles with point/blank
// flags and scans them onto an active-low segment bus with a dead-time gap per slot.
module disp_scan_hex #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     point_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    output logic [7:0]            SEGMENT,
    output logic [DIGITS-1:0]     AN
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   hex_q;
    logic [DIGITS-1:0]     point_q;
    logic [DIGITS-1:0]     blank_q;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic [DIGITS-1:0]     supp;
    logic [DIGITS-1:0]     an_sel;
    logic [3:0]            sel_hex;
    logic                  sel_pt;
    logic                  sel_bl;
    logic                  sel_sup;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Walk from the most significant digit down: a zero is only "leading" while
    // everything above it is zero or blanked.
    always_comb begin
        logic upper_dark;
        logic nib_zero;
        upper_dark = 1'b1;
        nib_zero   = 1'b0;
        supp       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib_zero   = (hex_q[4*i +: 4] == 4'h0);
            supp[i]    = lz_en && (i != 0) && nib_zero && upper_dark;
            upper_dark = upper_dark && (nib_zero || blank_q[i]);
        end
    end

    always_comb begin
        sel_hex = '0;
        sel_pt  = 1'b0;
        sel_bl  = 1'b0;
        sel_sup = 1'b0;
        an_sel  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_hex   = hex_q[4*i +: 4];
                sel_pt    = point_q[i];
                sel_bl    = blank_q[i];
                sel_sup   = supp[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        an_d  = '1;
        seg_d = 8'hFF;
        if (cnt_q >= GAP_END) begin
            an_d = an_sel;
            if (!sel_bl) begin
                seg_d = {~sel_pt, sel_sup ? 7'h7F : hex7(sel_hex)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            hex_q   <= '0;
            point_q <= '0;
            blank_q <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            if (load) begin
                hex_q   <= hex_in;
                point_q <= point_in;
                blank_q <= blank_in;
            end
        end
    end

    assign SEGMENT = seg_q;
    assign AN      = an_q;

endmodule
